// File: rtl/mem_stage_ldx_pkg.sv
// Shared encodings and bus-length constants for the MEM stage and its helpers.
package mem_stage_ldx_pkg;

    localparam int unsigned DATA_W_DEF    = 32;
    localparam int unsigned RF_ADDR_W_DEF = 5;
    localparam int unsigned PC_W          = 32;
    localparam int unsigned MEMOP_W       = 3;

    localparam logic [MEMOP_W-1:0] MEMOP_LB  = 3'd0;
    localparam logic [MEMOP_W-1:0] MEMOP_LBU = 3'd1;
    localparam logic [MEMOP_W-1:0] MEMOP_LH  = 3'd2;
    localparam logic [MEMOP_W-1:0] MEMOP_LHU = 3'd3;
    localparam logic [MEMOP_W-1:0] MEMOP_LW  = 3'd4;
    localparam logic [MEMOP_W-1:0] MEMOP_LD  = 3'd5;

    // pc, alu, mul, res_from_mul, res_from_mem, mem_op, req_sent, dest, gr_we
    localparam int unsigned ES2MS_BUS_LEN =
        PC_W + 2 * DATA_W_DEF + 1 + 1 + MEMOP_W + 1 + RF_ADDR_W_DEF + 1;
    // pc, gr_we, dest, final_result
    localparam int unsigned MS2WS_BUS_LEN = PC_W + 1 + RF_ADDR_W_DEF + DATA_W_DEF;

endpackage

// File: rtl/mem_stage_ldx_load_align_ext.sv
// Picks the addressed byte/half/word out of a read beat and sign/zero extends it.
module load_align_ext
    import mem_stage_ldx_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned OFF_W  = (DATA_W == 64) ? 3 : 2
) (
    input  logic [DATA_W-1:0]  rdata,
    input  logic [OFF_W-1:0]   addr_lo,
    input  logic [MEMOP_W-1:0] mem_op,
    output logic [DATA_W-1:0]  data
);

    logic [DATA_W-1:0] shifted;

    assign shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        data = shifted;
        case (mem_op)
            MEMOP_LB:  data = DATA_W'($signed(shifted[7:0]));
            MEMOP_LBU: data = DATA_W'(shifted[7:0]);
            MEMOP_LH:  data = DATA_W'($signed(shifted[15:0]));
            MEMOP_LHU: data = DATA_W'(shifted[15:0]);
            MEMOP_LW:  data = DATA_W'($signed(shifted[31:0]));
            default:   data = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage_ldx.sv
// MEM stage: waits for load responses, buffers early ones, drops responses owed to flushed loads.
// Optional misaligned-load detection is enabled with `define MEM_ALE_EN.
module mem_stage_ldx
    import mem_stage_ldx_pkg::*;
#(
    parameter int unsigned DATA_W          = DATA_W_DEF,
    parameter int unsigned RF_ADDR_W       = RF_ADDR_W_DEF,
    parameter int unsigned MAX_OUTSTANDING = 3
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 flush,
    input  logic                 es2ms_valid,
    output logic                 ms_allowin,
    input  logic [PC_W-1:0]      es_pc,
    input  logic [DATA_W-1:0]    es_alu_result,
    input  logic [DATA_W-1:0]    es_mul_result,
    input  logic                 es_res_from_mul,
    input  logic                 es_res_from_mem,
    input  logic [MEMOP_W-1:0]   es_mem_op,
    input  logic                 es_req_sent,
    input  logic [RF_ADDR_W-1:0] es_dest,
    input  logic                 es_gr_we,
    input  logic                 data_ok,
    input  logic [DATA_W-1:0]    data_rdata,
    input  logic                 ws_allowin,
    output logic                 ms2ws_valid,
    output logic [PC_W-1:0]      ms_pc,
    output logic                 ms_gr_we,
    output logic [RF_ADDR_W-1:0] ms_dest,
    output logic [DATA_W-1:0]    ms_final_result,
    output logic [RF_ADDR_W-1:0] ms_fwd_dest,
    output logic                 ms_fwd_ready,
    output logic [DATA_W-1:0]    ms_fwd_data
`ifdef MEM_ALE_EN
    ,
    output logic                 ms_ale,
    output logic [DATA_W-1:0]    ms_badv
`endif
);

    localparam int unsigned OFF_W = (DATA_W == 64) ? 3 : 2;
    localparam int unsigned CNT_W = 2;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic                 ms_valid;
    logic [PC_W-1:0]      pc_r;
    logic [DATA_W-1:0]    alu_r;
    logic                 res_from_mul_r;
    logic                 res_from_mem_r;
    logic [MEMOP_W-1:0]   mem_op_r;
    logic                 req_sent_r;
    logic [RF_ADDR_W-1:0] dest_r;
    logic                 gr_we_r;
    logic                 resp_buf_valid;
    logic [DATA_W-1:0]    resp_buf_data;
    logic [CNT_W-1:0]     discard_cnt;

    logic              need_resp;
    logic              resp_live;
    logic              got_resp;
    logic              ale;
    logic              ms_ready_go;
    logic              resp_drop;
    logic              flush_owed;
    logic [CNT_W-1:0]  cnt_dec;
    logic [DATA_W-1:0] load_rdata;
    logic [DATA_W-1:0] load_data;

    assign need_resp = ms_valid & req_sent_r;
    assign resp_live = data_ok & (discard_cnt == '0);
    assign got_resp  = resp_buf_valid | resp_live;

`ifdef MEM_ALE_EN
    // Misaligned loads never issued a request, so they must not wait for one.
    always_comb begin
        ale = 1'b0;
        if (ms_valid && res_from_mem_r) begin
            case (mem_op_r)
                MEMOP_LH, MEMOP_LHU: ale = alu_r[0];
                MEMOP_LW:            ale = |alu_r[1:0];
                MEMOP_LD:            ale = |alu_r[OFF_W-1:0];
                default:             ale = 1'b0;
            endcase
        end
    end
    assign ms_ale  = ale;
    assign ms_badv = ale ? alu_r : '0;
`else
    assign ale = 1'b0;
`endif

    assign ms_ready_go = ~need_resp | got_resp | ale;
    assign ms_allowin  = ~ms_valid | (ms_ready_go & ws_allowin);
    assign ms2ws_valid = ms_valid & ms_ready_go & ~flush;

    assign load_rdata = resp_buf_valid ? resp_buf_data : data_rdata;

    load_align_ext #(.DATA_W(DATA_W), .OFF_W(OFF_W)) u_align (
        .rdata   (load_rdata),
        .addr_lo (alu_r[OFF_W-1:0]),
        .mem_op  (mem_op_r),
        .data    (load_data)
    );

    assign ms_final_result = res_from_mem_r ? load_data
                           : res_from_mul_r ? es_mul_result
                           : alu_r;
    assign ms_pc        = pc_r;
    assign ms_dest      = dest_r;
    assign ms_gr_we     = ms_valid & gr_we_r & ~ale;
    assign ms_fwd_dest  = ms_gr_we ? dest_r : '0;
    assign ms_fwd_ready = ms_valid & ms_ready_go;
    assign ms_fwd_data  = ms_final_result;

    // Stale responses are retired before a flushed, still-owed request is counted.
    assign resp_drop  = data_ok & (discard_cnt != '0);
    assign flush_owed = flush & need_resp & ~got_resp;
    assign cnt_dec    = discard_cnt - CNT_W'(resp_drop);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ms_valid       <= 1'b0;
            pc_r           <= '0;
            alu_r          <= '0;
            res_from_mul_r <= 1'b0;
            res_from_mem_r <= 1'b0;
            mem_op_r       <= '0;
            req_sent_r     <= 1'b0;
            dest_r         <= '0;
            gr_we_r        <= 1'b0;
            resp_buf_valid <= 1'b0;
            resp_buf_data  <= '0;
            discard_cnt    <= '0;
        end else begin
            if (flush) begin
                ms_valid <= 1'b0;
            end else if (ms_allowin) begin
                ms_valid <= es2ms_valid;
            end

            if (es2ms_valid && ms_allowin && !flush) begin
                pc_r           <= es_pc;
                alu_r          <= es_alu_result;
                res_from_mul_r <= es_res_from_mul;
                res_from_mem_r <= es_res_from_mem;
                mem_op_r       <= es_mem_op;
                req_sent_r     <= es_req_sent;
                dest_r         <= es_dest;
                gr_we_r        <= es_gr_we;
            end

            if (flush || (ms2ws_valid && ws_allowin)) begin
                resp_buf_valid <= 1'b0;
            end else if (resp_live && need_resp && !resp_buf_valid && !ws_allowin) begin
                resp_buf_valid <= 1'b1;
                resp_buf_data  <= data_rdata;
            end

            if (flush_owed && cnt_dec != CNT_MAX) begin
                discard_cnt <= cnt_dec + CNT_W'(1);
            end else begin
                discard_cnt <= cnt_dec;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ldx.sv
// Directed self-checking bench for mem_stage_ldx (default 32-bit build).
module tb_mem_stage_ldx;
    import mem_stage_ldx_pkg::*;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        es2ms_valid;
    logic        ms_allowin;
    logic [31:0] es_pc;
    logic [31:0] es_alu_result;
    logic [31:0] es_mul_result;
    logic        es_res_from_mul;
    logic        es_res_from_mem;
    logic [2:0]  es_mem_op;
    logic        es_req_sent;
    logic [4:0]  es_dest;
    logic        es_gr_we;
    logic        data_ok;
    logic [31:0] data_rdata;
    logic        ws_allowin;
    logic        ms2ws_valid;
    logic [31:0] ms_pc;
    logic        ms_gr_we;
    logic [4:0]  ms_dest;
    logic [31:0] ms_final_result;
    logic [4:0]  ms_fwd_dest;
    logic        ms_fwd_ready;
    logic [31:0] ms_fwd_data;

    int checks = 0;
    int errors = 0;

    mem_stage_ldx dut (
        .clk             (clk),
        .resetn          (resetn),
        .flush           (flush),
        .es2ms_valid     (es2ms_valid),
        .ms_allowin      (ms_allowin),
        .es_pc           (es_pc),
        .es_alu_result   (es_alu_result),
        .es_mul_result   (es_mul_result),
        .es_res_from_mul (es_res_from_mul),
        .es_res_from_mem (es_res_from_mem),
        .es_mem_op       (es_mem_op),
        .es_req_sent     (es_req_sent),
        .es_dest         (es_dest),
        .es_gr_we        (es_gr_we),
        .data_ok         (data_ok),
        .data_rdata      (data_rdata),
        .ws_allowin      (ws_allowin),
        .ms2ws_valid     (ms2ws_valid),
        .ms_pc           (ms_pc),
        .ms_gr_we        (ms_gr_we),
        .ms_dest         (ms_dest),
        .ms_final_result (ms_final_result),
        .ms_fwd_dest     (ms_fwd_dest),
        .ms_fwd_ready    (ms_fwd_ready),
        .ms_fwd_data     (ms_fwd_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are changed.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for a single cycle; caller ensures ms_allowin is high.
    task automatic issue(input logic [31:0] pc, input logic [31:0] alu, input logic mem,
                         input logic mul, input logic [2:0] op, input logic req,
                         input logic [4:0] dest, input logic we);
        es_pc           = pc;
        es_alu_result   = alu;
        es_res_from_mem = mem;
        es_res_from_mul = mul;
        es_mem_op       = op;
        es_req_sent     = req;
        es_dest         = dest;
        es_gr_we        = we;
        es2ms_valid     = 1'b1;
        tick();
        es2ms_valid     = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; flush = 1'b0; es2ms_valid = 1'b0;
        es_pc = '0; es_alu_result = '0; es_mul_result = '0;
        es_res_from_mul = 1'b0; es_res_from_mem = 1'b0; es_mem_op = '0;
        es_req_sent = 1'b0; es_dest = '0; es_gr_we = 1'b0;
        data_ok = 1'b0; data_rdata = '0; ws_allowin = 1'b1;

        // Reset state
        tick(); tick();
        @(negedge clk);
        chk("rst_valid",    64'(ms2ws_valid), 64'd0);
        chk("rst_allowin",  64'(ms_allowin), 64'd1);
        chk("rst_gr_we",    64'(ms_gr_we), 64'd0);
        chk("rst_fwd_dest", 64'(ms_fwd_dest), 64'd0);
        chk("rst_fwd_rdy",  64'(ms_fwd_ready), 64'd0);
        chk("rst_pc",       64'(ms_pc), 64'd0);
        chk("rst_result",   64'(ms_final_result), 64'd0);
        tick();
        resetn = 1'b1;

        // ALU instruction passes in one cycle
        issue(32'h100, 32'h1234, 1'b0, 1'b0, MEMOP_LW, 1'b0, 5'd5, 1'b1);
        @(negedge clk);
        chk("add_valid",    64'(ms2ws_valid), 64'd1);
        chk("add_result",   64'(ms_final_result), 64'h1234);
        chk("add_fwd_rdy",  64'(ms_fwd_ready), 64'd1);
        chk("add_fwd_dest", 64'(ms_fwd_dest), 64'd5);
        chk("add_pc",       64'(ms_pc), 64'h100);
        chk("add_fwd_data", 64'(ms_fwd_data), 64'h1234);
        tick();

        // Multiply result selected, no register write
        es_mul_result = 32'hABCD;
        issue(32'h104, 32'h9999, 1'b0, 1'b1, MEMOP_LW, 1'b0, 5'd7, 1'b0);
        @(negedge clk);
        chk("mul_result",   64'(ms_final_result), 64'hABCD);
        chk("mul_fwd_dest", 64'(ms_fwd_dest), 64'd0);
        chk("mul_gr_we",    64'(ms_gr_we), 64'd0);
        tick();

        // LB at offset 3, response after three stall cycles
        issue(32'h108, 32'h1003, 1'b1, 1'b0, MEMOP_LB, 1'b1, 5'd8, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lb_stall_valid", 64'(ms2ws_valid), 64'd0);
            chk("lb_stall_fwd",   64'(ms_fwd_ready), 64'd0);
            chk("lb_stall_allow", 64'(ms_allowin), 64'd0);
            tick();
        end
        data_ok = 1'b1; data_rdata = 32'h80FF_FFFF;
        @(negedge clk);
        chk("lb_valid",  64'(ms2ws_valid), 64'd1);
        chk("lb_result", 64'(ms_final_result), 64'hFFFF_FF80);
        tick();
        data_ok = 1'b0;

        // LBU same address, single-cycle response
        issue(32'h10C, 32'h1003, 1'b1, 1'b0, MEMOP_LBU, 1'b1, 5'd9, 1'b1);
        data_ok = 1'b1; data_rdata = 32'h80FF_FFFF;
        @(negedge clk);
        chk("lbu_valid",  64'(ms2ws_valid), 64'd1);
        chk("lbu_result", 64'(ms_final_result), 64'h0000_0080);
        tick();
        data_ok = 1'b0;

        // LH offset 2 with WB stalled: response is buffered
        issue(32'h110, 32'h2002, 1'b1, 1'b0, MEMOP_LH, 1'b1, 5'd10, 1'b1);
        ws_allowin = 1'b0; data_ok = 1'b1; data_rdata = 32'h8001_0000;
        @(negedge clk);
        chk("lh_cap_allow", 64'(ms_allowin), 64'd0);
        tick();
        data_ok = 1'b0; data_rdata = 32'h0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("lh_buf_valid",  64'(ms2ws_valid), 64'd1);
            chk("lh_buf_result", 64'(ms_final_result), 64'hFFFF_8001);
            chk("lh_buf_allow",  64'(ms_allowin), 64'd0);
            tick();
        end
        ws_allowin = 1'b1;
        @(negedge clk);
        chk("lh_rel_allow",  64'(ms_allowin), 64'd1);
        chk("lh_rel_result", 64'(ms_final_result), 64'hFFFF_8001);
        tick();
        @(negedge clk);
        chk("lh_buf_clear", 64'(dut.resp_buf_valid), 64'd0);
        chk("lh_gone",      64'(ms2ws_valid), 64'd0);

        // Flush a pending load, then discard its late response
        issue(32'h114, 32'h3000, 1'b1, 1'b0, MEMOP_LW, 1'b1, 5'd11, 1'b1);
        flush = 1'b1;
        @(negedge clk);
        chk("fl_valid", 64'(ms2ws_valid), 64'd0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("fl_cnt1",  64'(dut.discard_cnt), 64'd1);
        chk("fl_allow", 64'(ms_allowin), 64'd1);
        issue(32'h118, 32'h3004, 1'b1, 1'b0, MEMOP_LW, 1'b1, 5'd12, 1'b1);
        data_ok = 1'b1; data_rdata = 32'h0000_DEAD;
        @(negedge clk);
        chk("fl_drop_valid", 64'(ms2ws_valid), 64'd0);
        tick();
        data_rdata = 32'h0000_0055;
        @(negedge clk);
        chk("fl_cnt0",     64'(dut.discard_cnt), 64'd0);
        chk("fl2_valid",   64'(ms2ws_valid), 64'd1);
        chk("fl2_result",  64'(ms_final_result), 64'h55);
        tick();
        data_ok = 1'b0;

        // Reset during a pending load with a non-zero discard count
        issue(32'h11C, 32'h4000, 1'b1, 1'b0, MEMOP_LW, 1'b1, 5'd13, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        issue(32'h120, 32'h4004, 1'b1, 1'b0, MEMOP_LW, 1'b1, 5'd14, 1'b1);
        @(negedge clk);
        chk("rw_cnt1",  64'(dut.discard_cnt), 64'd1);
        chk("rw_stall", 64'(ms_fwd_ready), 64'd0);
        resetn = 1'b0;
        tick();
        @(negedge clk);
        chk("rw_valid", 64'(ms2ws_valid), 64'd0);
        chk("rw_allow", 64'(ms_allowin), 64'd1);
        chk("rw_cnt0",  64'(dut.discard_cnt), 64'd0);
        tick();
        resetn = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage_ldx.md
# mem_stage_ldx

Parametrised memory-access stage of the five-stage in-order core, between EXE and WB. It accepts an instruction from EXE and, for loads, waits for the data-bus response (`data_ok`) instead of assuming fixed one-cycle SRAM. It aligns and extends byte/half/word load data, selects the load, multiply or ALU result, and holds early responses in a one-entry buffer when WB stalls. After a pipeline flush it discards responses still owed to squashed requests.

## Interface
Parameters:
- DATA_W, 32, datapath/register width (32 or 64)
- RF_ADDR_W, 5, register index width
- MAX_OUTSTANDING, 3, upper bound of the discard counter (2-bit)

Ports:
- clk  in  1  clock; all state on posedge
- resetn  in  1  synchronous, active-low reset
- flush  in  1  squash the stage's instruction (exception/ertn from WB)
- es2ms_valid  in  1  EXE holds a valid instruction
- ms_allowin  out  1  MEM can accept this cycle
- es_pc  in  32  instruction PC
- es_alu_result  in  DATA_W  ALU result / effective address
- es_mul_result  in  DATA_W  multiplier result (arrives in MEM cycle)
- es_res_from_mul  in  1  select multiplier result
- es_res_from_mem  in  1  instruction is a load
- es_mem_op  in  3  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LD (DATA_W=64 only)
- es_req_sent  in  1  EXE issued a bus request for this instruction (load or store)
- es_dest  in  RF_ADDR_W  destination register
- es_gr_we  in  1  register write enable
- data_ok  in  1  data-bus response strobe
- data_rdata  in  DATA_W  response data
- ws_allowin  in  1  WB can accept
- ms2ws_valid  out  1  result valid toward WB
- ms_pc  out  32  PC to WB
- ms_gr_we  out  1  write enable to WB (gated by valid)
- ms_dest  out  RF_ADDR_W  destination to WB
- ms_final_result  out  DATA_W  write-back data
- ms_fwd_dest  out  RF_ADDR_W  forwarding destination; 0 when invalid or no write
- ms_fwd_ready  out  1  forwarding data available this cycle; low while a load waits
- ms_fwd_data  out  DATA_W  equals ms_final_result

## Operation
- State held: ms_valid, latched EXE fields, resp_buf (valid + data), discard_cnt.
- need_resp = ms_valid & req_sent.
- got_resp = resp_buf_valid, or data_ok with discard_cnt==0.
- ms_ready_go = ~need_resp | got_resp.
- ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin).
- ms2ws_valid = ms_valid & ms_ready_go & ~flush.
- Response steering:
  - data_ok with discard_cnt>0: decrement the counter; the response is dropped.
  - data_ok with discard_cnt==0 while ws_allowin low: store the data in resp_buf.
  - resp_buf clears when the instruction moves to WB.
- Load data: byte/half lane taken from address low bits (alu_result[1:0], or [2:0] when DATA_W=64). LB/LH/LW sign-extend; LBU/LHU zero-extend.
- Result select priority: load data, then mul result, then ALU result.
- flush:
  - ms_valid clears next cycle and resp_buf clears.
  - If need_resp and the response has not been received (not buffered, no data_ok this cycle), discard_cnt increments, saturating at MAX_OUTSTANDING.
  - A concurrent data_ok that clears the counter is treated before the increment.
- Reset state: ms_valid=0, resp_buf_valid=0, discard_cnt=0, latched fields 0. Outputs: ms2ws_valid=0, ms_allowin=1, ms_gr_we=0, ms_fwd_dest=0, ms_fwd_ready=0, ms_pc=0, ms_final_result=0.

## Timing
- Non-memory instruction: in MEM for 1 cycle; ms2ws_valid in the same cycle it is latched.
- Load: ms2ws_valid in the same cycle data_ok is seen (rdata path to ms_final_result is combinational). Latency = bus latency, minimum 1 cycle.
- The EXE latch fires only on es2ms_valid & ms_allowin; fields are stable while stalled.
- Buffered response is presented the cycle after capture and every cycle until WB accepts.
- flush together with es2ms_valid & ms_allowin: the incoming instruction is not latched.
- resetn low mid-wait: all state including discard_cnt is cleared. The bus is reset in the same cycle, so no stale response follows.

## Configuration
- MEM_ALE_EN:
  - Defined: misaligned load address (half not 2-aligned, word not 4-aligned) raises output ms_ale (1 bit, reset 0) and ms_badv (= address).
  - The instruction goes to WB with ms_gr_we forced 0, and ms_ready_go does not wait for a response.
  - EXE guarantees no request is issued for it.
- Undefined: ports ms_ale/ms_badv absent; the address is used as is, ignoring misalignment.

## Structure
- Shared package/header holds:
  - memory-op encodings (MEMOP_LB…MEMOP_LD)
  - DATA_W default
  - the ES2MS/MS2WS bus length constants
- Sub-module load_align_ext (combinational: rdata, addr low bits, mem_op → extended data), reused by future store-data/cache paths.

## Test plan
- ADD result 0x1234 with ws_allowin=1 → ms2ws_valid same cycle, ms_final_result=0x1234, ms_fwd_ready=1.
- LB at addr 0x...3, rdata 0x80FF_FF_FF, data_ok 3 cycles later → stall 3 cycles with ms_fwd_ready=0, then result 0xFFFFFF80; LBU → 0x00000080.
- LH at addr offset 2, rdata 0x8001_0000, with ws_allowin=0 when data_ok arrives → buffered. Result 0xFFFF8001 delivered when ws_allowin rises; ms_allowin stays 0 meanwhile.
- Load pending, flush asserted, next load issued → first data_ok (0xDEAD) discarded with discard_cnt 1→0; second response 0x55 written; no 0xDEAD reaches WB.
- resetn=0 during a pending load → next cycle ms2ws_valid=0, ms_allowin=1, discard_cnt=0.
- MEM_ALE_EN: LW at addr 0x1002 → ms_ale=1, ms_badv=0x1002, ms_gr_we=0, no wait for data_ok.
